// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection traffic-light pacing logic.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
//
// Contents: phase encodings matching the sequencing FSM state encoding, the
// width of the per-phase tick countdown, and the duration/class lookups.
package traffic_pkg;

    localparam logic [2:0] PH_N_GREEN  = 3'd0;
    localparam logic [2:0] PH_N_YELLOW = 3'd1;
    localparam logic [2:0] PH_RED_1    = 3'd2;
    localparam logic [2:0] PH_E_LEFT   = 3'd3;
    localparam logic [2:0] PH_E_GREEN  = 3'd4;
    localparam logic [2:0] PH_E_YELLOW = 3'd5;
    localparam logic [2:0] PH_RED_2    = 3'd6;
    localparam logic [2:0] PH_N_LEFT   = 3'd7;

    localparam int DUR_W = 6;
    typedef logic [DUR_W-1:0] dur_t;

    localparam dur_t DUR_ONE = dur_t'(1);

    // Tick count loaded on entry to phase p.
    function automatic dur_t phase_dur(
        input logic [2:0] p,
        input dur_t       green_t,
        input dur_t       yellow_t,
        input dur_t       red_t,
        input dur_t       left_t
    );
        dur_t d;
        d = green_t;
        case (p)
            PH_N_GREEN,  PH_E_GREEN:  d = green_t;
            PH_N_YELLOW, PH_E_YELLOW: d = yellow_t;
            PH_RED_1,    PH_RED_2:    d = red_t;
            PH_E_LEFT,   PH_N_LEFT:   d = left_t;
            default:                  d = green_t;
        endcase
        return d;
    endfunction

    // Greens and lefts may be cut short by an emergency request.
    function automatic logic is_trunc_phase(input logic [2:0] p);
        return (p == PH_N_GREEN) || (p == PH_E_LEFT) ||
               (p == PH_E_GREEN) || (p == PH_N_LEFT);
    endfunction

    // All-red phases are held for as long as an emergency request persists.
    function automatic logic is_red_phase(input logic [2:0] p);
        return (p == PH_RED_1) || (p == PH_RED_2);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler: emits one registered tick every TICK_DIV enabled cycles.
// Latency: tick is high for the cycle after the count reaches TICK_DIV-1.
// Backpressure: enable low freezes the count and the tick register in place.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; clears count and tick
//   enable in   high = count; low = hold all state
//   tick   out  one-cycle pulse (held, not re-issued, while enable is low)
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == CNT_LAST);

    // Holding tick while disabled lets the consumer see a tick that landed
    // just before a freeze once it is re-enabled, so freezes never lose time.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            tick <= at_last;
            cnt  <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Phase pacing for the traffic-light FSM: per-phase tick countdown and go pulse.
// Latency: go rises one cycle after the tick that sees remaining==1; one cycle wide.
// Backpressure: enable low freezes prescaler and countdown and suppresses go.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   enable     in   run / freeze
//   emergency  in   pre-emption: truncate greens/lefts, hold all-reds
//   left_req   in   left-lane sensor (only used with PHASE_TIMER_LEFT_SKIP_EN)
//   go         out  one-cycle advance pulse to the sequencing FSM
//   phase      out  current phase, FSM state encoding
//   remaining  out  ticks left in current phase
//   tick       out  prescaler pulse
//
// Build option: define PHASE_TIMER_LEFT_SKIP_EN to shrink a left phase to a
// single tick when no left-lane demand is present on entry.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int RED_T    = 2,
    parameter int LEFT_T   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             emergency,
    input  logic             left_req,
    output logic             go,
    output logic [2:0]       phase,
    output logic [DUR_W-1:0] remaining,
    output logic             tick
);

    localparam dur_t GREEN_D  = dur_t'(GREEN_T);
    localparam dur_t YELLOW_D = dur_t'(YELLOW_T);
    localparam dur_t RED_D    = dur_t'(RED_T);
    localparam dur_t LEFT_D   = dur_t'(LEFT_T);

    logic       go_q;
    logic [2:0] next_phase;
    dur_t       entry_dur;
    logic       emg_trunc;
    logic       emg_hold;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign next_phase = phase + 3'd1;

    always_comb begin
        entry_dur = phase_dur(next_phase, GREEN_D, YELLOW_D, RED_D, LEFT_D);
`ifdef PHASE_TIMER_LEFT_SKIP_EN
        if (((next_phase == PH_E_LEFT) || (next_phase == PH_N_LEFT)) && !left_req) begin
            entry_dur = DUR_ONE;
        end
`endif
    end

`ifndef PHASE_TIMER_LEFT_SKIP_EN
    // Sensor is not consulted in this build.
    logic unused_left_req;
    assign unused_left_req = left_req;
`endif

    // Truncation only matters while more than one tick remains; at 1 the
    // normal tick path already fires go next.
    assign emg_trunc = emergency && is_trunc_phase(phase) && (remaining > DUR_ONE);
    assign emg_hold  = emergency && is_red_phase(phase);

    // Priority: reset > freeze > advance > emergency > tick countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= PH_N_GREEN;
            remaining <= GREEN_D;
            go_q      <= 1'b0;
        end else if (!enable) begin
            // A pending go is dropped; remaining stays at 1 so the first
            // tick after re-enable re-arms it.
            go_q <= 1'b0;
        end else if (go_q) begin
            phase     <= next_phase;
            remaining <= entry_dur;
            go_q      <= 1'b0;
        end else if (emg_trunc) begin
            remaining <= DUR_ONE;
        end else if (emg_hold) begin
            remaining <= remaining;
        end else if (tick) begin
            if (remaining > DUR_ONE) begin
                remaining <= remaining - DUR_ONE;
            end else begin
                go_q <= 1'b1;
            end
        end
    end

    // The FSM must never see an advance while the timer is frozen.
    assign go = go_q & enable;

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int GREEN_T  = 5;
    localparam int YELLOW_T = 2;
    localparam int RED_T    = 1;
    localparam int LEFT_T   = 3;

`ifdef PHASE_TIMER_LEFT_SKIP_EN
    localparam int LEFT_NOREQ_GO = 37;
`else
    localparam int LEFT_NOREQ_GO = 45;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       emergency = 1'b0;
    logic       left_req = 1'b0;
    logic       go;
    logic [2:0] phase;
    logic [5:0] remaining;
    logic       tick;

    int cyc = 0;
    int r_edge = 0;
    int n_chk = 0;
    int n_pass = 0;

    phase_timer #(
        .TICK_DIV (TICK_DIV),
        .GREEN_T  (GREEN_T),
        .YELLOW_T (YELLOW_T),
        .RED_T    (RED_T),
        .LEFT_T   (LEFT_T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .emergency (emergency),
        .left_req  (left_req),
        .go        (go),
        .phase     (phase),
        .remaining (remaining),
        .tick      (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Edge index (relative to the last reset edge) of the next go pulse, -1 on timeout.
    task automatic wait_go(output int at);
        at = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (go) begin
                at = cyc - r_edge;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r_edge = cyc;
    endtask

    task automatic wait_to(input int k);
        while (cyc - r_edge < k) @(negedge clk);
    endtask

    initial begin
        int at, prev, gcnt;
        int durs [8];
        int offs [8];
        durs = '{5, 2, 1, 3, 5, 2, 1, 3};
        offs = '{8, 12, 24, 44, 52, 56, 68, 88};

        // Reset state and first go latency
        repeat (3) @(negedge clk);
        chk("rst_go", go, 0);
        chk("rst_tick", tick, 0);
        chk("rst_phase", phase, 0);
        chk("rst_rem", remaining, 5);
        reset = 1'b0;
        r_edge = cyc;
        wait_go(at);
        chk("first_go", at, 21);
        @(negedge clk);
        chk("go_width", go, 0);
        chk("p1_phase", phase, 1);
        chk("p1_rem", remaining, 2);

        // One full free-running cycle of eight phases
        for (int k = 0; k < 8; k++) begin
            wait_go(at);
            chk($sformatf("cyc_go%0d", k), at - 21, offs[k]);
            @(negedge clk);
            chk($sformatf("cyc_phase%0d", k), phase, (k + 2) % 8);
            chk($sformatf("cyc_rem%0d", k), remaining, durs[(k + 2) % 8]);
        end

        // Emergency: truncate green, normal yellow, hold red
        do_reset();
        wait_to(6);
        chk("emg_pre_rem", remaining, 4);
        emergency = 1'b1;
        @(negedge clk);
        chk("emg_trunc_rem", remaining, 1);
        wait_go(at);
        chk("emg_green_go", at, 9);
        prev = at;
        wait_go(at);
        chk("emg_yellow_len", at - prev, 8);
        @(negedge clk);
        chk("emg_red_phase", phase, 2);
        gcnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (go) gcnt++;
        end
        chk("emg_red_nogo", gcnt, 0);
        chk("emg_red_held", phase, 2);
        chk("emg_red_rem", remaining, 1);
        emergency = 1'b0;
        wait_go(at);
        chk("emg_release_go", at, 121);

        // Enable low for 10 cycles mid-green
        do_reset();
        wait_to(6);
        enable = 1'b0;
        gcnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (go) gcnt++;
        end
        chk("dis_nogo", gcnt, 0);
        chk("dis_rem_frozen", remaining, 4);
        enable = 1'b1;
        wait_go(at);
        chk("dis_go_delay", at, 31);

        // Reset mid-phase (phase 4, remaining 3)
        do_reset();
        wait_to(54);
        chk("mid_phase", phase, 4);
        chk("mid_rem", remaining, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_phase", phase, 0);
        chk("mid_rst_rem", remaining, 5);
        chk("mid_rst_go", go, 0);
        chk("mid_rst_tick", tick, 0);
        reset = 1'b0;
        r_edge = cyc;

        // Left phase with and without lane demand
        for (int lr = 0; lr < 2; lr++) begin
            left_req = lr[0];
            do_reset();
            wait_go(at);
            wait_go(at);
            wait_go(at);
            chk($sformatf("left%0d_entry_go", lr), at, 33);
            wait_go(at);
            chk($sformatf("left%0d_exit_go", lr), at, (lr == 0) ? LEFT_NOREQ_GO : 45);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_timer.md
# phase_timer

Upstream pacing stage for the intersection traffic-light controller. Divides the system clock into a slow tick, counts down a per-phase duration, and issues the one-cycle `go` pulse that advances the light-sequencing FSM. Keeps an internal phase index in lockstep with the FSM's eight states and applies emergency pre-emption by shortening greens/lefts and holding all-red phases.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clk cycles per tick, ≥2
- `GREEN_T`, 20: ticks in N_GREEN / E_GREEN, 1..63
- `YELLOW_T`, 3: ticks in N_YELLOW / E_YELLOW, 1..63
- `RED_T`, 2: ticks in RED_1 / RED_2, 1..63
- `LEFT_T`, 8: ticks in E_LEFT / N_LEFT, 1..63

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  high = run; low = freeze prescaler and countdown
- `emergency`  in  1  pre-emption request, level-sensitive, synchronous to `clk`
- `left_req`  in  1  left-lane sensor; used only with `PHASE_TIMER_LEFT_SKIP_EN`
- `go`  out  1  one-cycle advance pulse to the sequencing FSM
- `phase`  out  3  current phase, same encoding as the FSM state
- `remaining`  out  6  ticks left in current phase
- `tick`  out  1  one-cycle prescaler pulse

## Operation
- Phase encoding: 0 N_GREEN, 1 N_YELLOW, 2 RED_1, 3 E_LEFT, 4 E_GREEN, 5 E_YELLOW, 6 RED_2, 7 N_LEFT; 7 wraps to 0.
- Duration lookup DUR(p): 0,4→GREEN_T; 1,5→YELLOW_T; 2,6→RED_T; 3,7→LEFT_T.
- Prescaler counts 0..TICK_DIV-1, wraps; `tick` is registered high for the cycle after count reaches TICK_DIV-1.
- On a cycle with `tick` high: if `remaining`>1, decrement; if `remaining`==1, set `go` for the next cycle and hold `remaining` at 1.
- On the edge where `go` is high: `phase`←phase+1 mod 8, `remaining`←DUR(new phase), `go`←0. `phase` therefore changes on the same edge as the FSM state.
- Emergency, `emergency` high, phase in {0,3,4,7}, `remaining`>1: `remaining`←1 on that edge, so `go` fires at the next tick.
- Emergency, phase in {2,6}: no decrement and no `go` while high. Countdown resumes from the held value on release.
- Emergency in {1,5}: normal countdown; yellow is never shortened.
- `enable` low: prescaler, countdown, emergency truncation, and `go` generation all frozen; `go` forced 0. A pending `go` is dropped and re-armed at the next tick after re-enable.
- Priority: `reset` > `enable` low > go-advance > emergency > tick decrement.
- Reset values: `go`=0, `tick`=0, `phase`=0, `remaining`=GREEN_T, prescaler=0.

## Timing
- `go` latency: exactly one cycle after the tick that sees `remaining`==1. Width is always one cycle.
- Phase length with no emergency: DUR(p)·TICK_DIV cycles. The prescaler free-runs across phase changes.
- Reset mid-phase takes effect at the next edge; there is no partial state.

## Configuration
- `PHASE_TIMER_LEFT_SKIP_EN` defined: on entry to phase 3 or 7, if `left_req`==0, `remaining` is loaded with 1 instead of LEFT_T, giving a minimal one-tick left phase.
- `PHASE_TIMER_LEFT_SKIP_EN` undefined: `left_req` is ignored and left phases always last LEFT_T.

## Structure
- Shared package `traffic_pkg` holds the phase localparams (3'd0..3'd7), the 6-bit duration width, and a `phase_dur` function.
- Sub-module `tick_prescaler` holds the counter plus registered `tick`, with `TICK_DIV` and `enable` as inputs.

## Test plan
All scenarios use TICK_DIV=4, GREEN_T=5, YELLOW_T=2, RED_T=1, LEFT_T=3, enable=1.
- Reset, release, run -> first `go` high exactly 21 cycles after the reset-release edge, 1 cycle wide; `phase`=1 and `remaining`=2 after that edge.
- Free run, one full cycle -> 8 `go` pulses, 88 cycles apart end-to-end; `phase` returns to 0 with `remaining`=5.
- `emergency` raised in phase 0 with `remaining`=4 -> `remaining`=1 next cycle; `go` at the next tick. Yellow still lasts 8 cycles. RED_1 holds with no `go` for 100 cycles of emergency; after release, `go` follows at the next tick.
- `enable` low for 10 cycles mid-green -> `go` delayed by exactly 10 cycles versus reference run; `go` never asserted while low.
- `reset` pulsed while phase=4, remaining=3 -> next cycle `phase`=0, `remaining`=5, `go`=0, `tick`=0.
- Macro defined, entering phase 3 -> `left_req`=0: `go` after 1 tick (4 cycles); `left_req`=1: `go` after 3 ticks (12 cycles).
